// File: rtl/dmem_pkg.sv
// Shared types for the pipelined data memory: FSM states, default geometry and response record.
package dmem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 64;
  localparam int LANES      = DATA_W_DEF / 8;
  localparam int IDX_W      = $clog2(DEPTH_DEF);

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [DATA_W_DEF-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Stallable response delay line: STAGES registers deep, every stage holds while i_stall is high.
module dmem_rsp_pipe
  import dmem_pkg::*;
#(
  parameter int  STAGES  = 2,
  parameter type rsp_w_t = rsp_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_stall,
  input  rsp_w_t i_rsp,
  output rsp_w_t o_rsp
);

  rsp_w_t r_stg [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) r_stg[s] <= '0;
    end else if (!i_stall) begin
      r_stg[0] <= i_rsp;
      for (int s = 1; s < STAGES; s++) r_stg[s] <= r_stg[s-1];
    end
  end

  assign o_rsp = r_stg[STAGES-1];

endmodule

// File: rtl/dmem_pipe.sv
// Word-addressed data memory with valid/ready requests, byte-lane writes, range check,
// post-reset clear sweep and an RD_LAT-cycle in-order response pipeline.
module dmem_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NL = DATA_W / 8;
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } rsp_dw_t;

  state_t            r_state;
  logic [IW-1:0]     r_clr_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_stall;
  logic              w_acc;
  logic              w_in_range;
  logic [IW-1:0]     w_idx;
  rsp_dw_t           w_stg_in;
  rsp_dw_t           w_stg_out;

  assign w_stall    = w_stg_out.valid && !rsp_ready;
  assign req_ready  = (r_state == RUN) && !w_stall;
  assign w_acc      = req_valid && req_ready;
  // Full-width compare: high address bits must not alias into the array.
  assign w_in_range = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
  assign w_idx      = req_addr[IW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= INIT;
      r_clr_cnt <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == IW'(DEPTH - 1)) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_acc && req_we && w_in_range) begin
      for (int l = 0; l < NL; l++) begin
        if (req_be[l]) r_mem[w_idx][l*8 +: 8] <= req_wdata[l*8 +: 8];
      end
    end
  end

  always_comb begin
    w_stg_in.valid = w_acc;
    w_stg_in.err   = w_acc && !w_in_range;
    w_stg_in.rdata = '0;
    if (w_acc && !req_we && w_in_range) w_stg_in.rdata = r_mem[w_idx];
  end

  dmem_rsp_pipe #(
    .STAGES  (RD_LAT),
    .rsp_w_t (rsp_dw_t)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_stall (w_stall),
    .i_rsp   (w_stg_in),
    .o_rsp   (w_stg_out)
  );

  assign rsp_valid = w_stg_out.valid;
  assign rsp_err   = w_stg_out.err;
  assign rsp_rdata = w_stg_out.rdata;

endmodule
